// File: rtl/light_pkg.sv
// ---------------------------------------------------------------------------
// light_pkg
// This package is shared by the light phase sequencer and the downstream light
// controller. It holds:
//   COLOR_*        3-bit phase codes that appear on the color output.
//   light_state_t  The sequencer state type. Its encodings match the color
//                  codes, so the color output can come straight from the
//                  state register.
// ---------------------------------------------------------------------------
package light_pkg;

   localparam logic [2:0] COLOR_RED    = 3'b000;
   localparam logic [2:0] COLOR_GREEN  = 3'b001;
   localparam logic [2:0] COLOR_YELLOW = 3'b010;

   typedef enum logic [2:0] {
      ST_RED    = COLOR_RED,
      ST_GREEN  = COLOR_GREEN,
      ST_YELLOW = COLOR_YELLOW
   } light_state_t;

endpackage

// File: rtl/light_phase_sequencer_counter.sv
// ---------------------------------------------------------------------------
// phase_counter
// An 8-bit down counter that holds the cycles left in the current phase.
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset; the counter goes to RST_VAL
//   i_load      load i_load_val on the next edge; this has priority over
//               counting
//   i_load_val  value to load
//   i_en        decrement on the next edge while the count is non-zero
//   o_count     registered count
//   o_zero      high when the count is zero
// ---------------------------------------------------------------------------
module phase_counter #(
   parameter logic [7:0] RST_VAL = 8'd0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_en,
   output logic [7:0] o_count,
   output logic       o_zero
);

   logic [7:0] r_count;

   // Count register: a load wins; otherwise count down and stop at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= RST_VAL;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != 8'd0)) begin
         r_count <= r_count - 8'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == 8'd0);

endmodule

// File: rtl/light_phase_sequencer.sv
// ---------------------------------------------------------------------------
// light_phase_sequencer
// Steps through the light phases RED -> GREEN -> YELLOW -> RED. Each phase
// lasts a fixed number of enabled clock cycles. A pedestrian request can cut
// GREEN short.
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   enable      advance timing when high; state and count freeze when low
//   ped_req     pedestrian request, level or pulse
//   color       current phase code (see light_pkg)
//   remaining   cycles left in the phase minus one
//   phase_done  one-cycle pulse in the first cycle of each new phase
//   ped_ack     one-cycle pulse on entry to RED when a request was pending
// Build option: define LIGHT_SEQ_PED_EN to enable pedestrian handling.
// Without it, ped_req is ignored, ped_ack is held low, and GREEN always runs
// for its full length.
// ---------------------------------------------------------------------------
module light_phase_sequencer
   import light_pkg::*;
#(
   parameter int RED_CYC    = 8,
   parameter int GREEN_CYC  = 10,
   parameter int YELLOW_CYC = 3,
   parameter int PED_CUT    = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       ped_req,
   output logic [2:0] color,
   output logic [7:0] remaining,
   output logic       phase_done,
   output logic       ped_ack
);

   localparam logic [7:0] RED_LEN    = 8'(RED_CYC - 1);
   localparam logic [7:0] GREEN_LEN  = 8'(GREEN_CYC - 1);
   localparam logic [7:0] YELLOW_LEN = 8'(YELLOW_CYC - 1);
   localparam logic [7:0] PED_LEN    = 8'(PED_CUT);

   light_state_t r_state;
   logic         r_phase_done;
   light_state_t w_next;
   logic [7:0]   w_next_len;
   logic         w_illegal;
   logic         w_load;
   logic [7:0]   w_load_val;
   logic [7:0]   w_count;
   logic         w_zero;
   logic         w_shorten;

   phase_counter #(
      .RST_VAL (RED_LEN)
   ) u_phase_counter (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_en       (enable),
      .o_count    (w_count),
      .o_zero     (w_zero)
   );

   // Work out the successor phase and its length, and what to load into the
   // counter. An illegal state reloads a full RED whatever enable is.
   always_comb begin
      w_illegal  = 1'b0;
      w_next     = ST_RED;
      w_next_len = RED_LEN;
      case (r_state)
         ST_RED: begin
            w_next     = ST_GREEN;
            w_next_len = GREEN_LEN;
         end
         ST_GREEN: begin
            w_next     = ST_YELLOW;
            w_next_len = YELLOW_LEN;
         end
         ST_YELLOW: begin
            w_next     = ST_RED;
            w_next_len = RED_LEN;
         end
         default: begin
            w_illegal  = 1'b1;
            w_next     = ST_RED;
            w_next_len = RED_LEN;
         end
      endcase

      w_load     = 1'b0;
      w_load_val = w_next_len;
      if (w_illegal) begin
         w_load     = 1'b1;
         w_load_val = RED_LEN;
      end else if (enable && w_zero) begin
         w_load     = 1'b1;
         w_load_val = w_next_len;
      end else if (w_shorten) begin
         w_load     = 1'b1;
         w_load_val = PED_LEN;
      end else begin
         w_load     = 1'b0;
         w_load_val = w_next_len;
      end
   end

   // Phase state machine. The phase_done pulse is registered so that it
   // lines up with the first cycle of the new phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_RED;
         r_phase_done <= 1'b0;
      end else if (w_illegal) begin
         r_state      <= ST_RED;
         r_phase_done <= 1'b0;
      end else if (enable && w_zero) begin
         r_state      <= w_next;
         r_phase_done <= 1'b1;
      end else begin
         r_state      <= r_state;
         r_phase_done <= 1'b0;
      end
   end

`ifdef LIGHT_SEQ_PED_EN
   logic r_ped_pending;
   logic r_ped_ack;
   logic w_ped_any;
   logic w_serve;

   // A request in the current cycle counts right away, so a pulse can
   // shorten GREEN on the very next edge.
   assign w_ped_any = r_ped_pending | ped_req;
   assign w_shorten = enable && (r_state == ST_GREEN) && w_ped_any &&
                      (w_count > PED_LEN);
   assign w_serve   = !w_illegal && enable && w_zero &&
                      (w_next == ST_RED) && r_ped_pending;

   // Pending request latch and acknowledge pulse. When a request arrives in
   // the same cycle that serves the pending one, the new request stays
   // pending (set wins over clear).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ped_pending <= 1'b0;
         r_ped_ack     <= 1'b0;
      end else if (w_serve) begin
         r_ped_pending <= ped_req;
         r_ped_ack     <= 1'b1;
      end else begin
         r_ped_pending <= r_ped_pending | ped_req;
         r_ped_ack     <= 1'b0;
      end
   end

   assign ped_ack = r_ped_ack;
`else
   logic w_unused_ped;

   assign w_shorten    = 1'b0;
   assign w_unused_ped = ^{ped_req, PED_LEN};
   assign ped_ack      = 1'b0;
`endif

   assign color      = r_state;
   assign remaining  = w_count;
   assign phase_done = r_phase_done;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_light_phase_sequencer
// Directed bench for light_phase_sequencer. Parameters: RED=4, GREEN=6,
// YELLOW=2, PED_CUT=1. Inputs change and outputs are sampled on the falling
// clock edge. The pedestrian sequences depend on LIGHT_SEQ_PED_EN.
// ---------------------------------------------------------------------------
module tb_light_phase_sequencer;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic       ped_req;
   logic [2:0] color;
   logic [7:0] remaining;
   logic       phase_done;
   logic       ped_ack;

   int checks = 0;
   int errors = 0;

   light_phase_sequencer #(
      .RED_CYC    (4),
      .GREEN_CYC  (6),
      .YELLOW_CYC (2),
      .PED_CUT    (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .ped_req    (ped_req),
      .color      (color),
      .remaining  (remaining),
      .phase_done (phase_done),
      .ped_ack    (ped_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [2:0] c, input logic [7:0] r,
                       input logic pd, input logic ack);
      check({tag, ".color"}, {5'd0, color}, {5'd0, c});
      check({tag, ".remaining"}, remaining, r);
      check({tag, ".phase_done"}, {7'd0, phase_done}, {7'd0, pd});
      check({tag, ".ped_ack"}, {7'd0, ped_ack}, {7'd0, ack});
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a falling edge with the DUT in YELLOW, remaining 0.
   task automatic reset_mid_yellow();
      ped_req = 1'b0;
      reset_n = 1'b0;
      #1;
      chk4("rst_async", 3'b000, 8'd3, 1'b0, 1'b0);
      step(1);
      chk4("rst_held", 3'b000, 8'd3, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk4("post_rst_red", 3'b000, 8'(3 - i), 1'b0, 1'b0);
         step(1);
      end
      chk4("post_rst_green", 3'b001, 8'd5, 1'b1, 1'b0);
      step(1);
      chk4("post_rst_green_full", 3'b001, 8'd4, 1'b0, 1'b0);
   endtask

   initial begin
      int pos;
      logic [2:0] ec;
      logic [7:0] er;
      logic       ep;

      reset_n = 1'b1;
      enable  = 1'b0;
      ped_req = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      chk4("reset", 3'b000, 8'd3, 1'b0, 1'b0);

      // Free run for 24 cycles with enable high.
      @(negedge clk);
      reset_n = 1'b1;
      enable  = 1'b1;
      for (int k = 0; k < 24; k++) begin
         pos = k % 12;
         if (pos < 4) begin
            ec = 3'b000; er = 8'(3 - pos);
         end else if (pos < 10) begin
            ec = 3'b001; er = 8'(9 - pos);
         end else begin
            ec = 3'b010; er = 8'(11 - pos);
         end
         ep = (k > 0) && (pos == 0 || pos == 4 || pos == 10);
         chk4("run", ec, er, ep, 1'b0);
         step(1);
      end
      chk4("run_wrap_red", 3'b000, 8'd3, 1'b1, 1'b0);

      // Hold enable low for 5 cycles in the middle of GREEN.
      step(6);
      chk4("pre_freeze", 3'b001, 8'd3, 1'b0, 1'b0);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk4("freeze", 3'b001, 8'd3, 1'b0, 1'b0);
      end
      enable = 1'b1;
      step(1);
      chk4("resume", 3'b001, 8'd2, 1'b0, 1'b0);
      step(5);
      chk4("resume_red", 3'b000, 8'd3, 1'b1, 1'b0);

`ifdef LIGHT_SEQ_PED_EN
      // A request at green remaining=4 cuts GREEN to remaining=1.
      step(5);
      chk4("p1_green4", 3'b001, 8'd4, 1'b0, 1'b0);
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      chk4("p1_cut", 3'b001, 8'd1, 1'b0, 1'b0);
      step(1);
      chk4("p1_green0", 3'b001, 8'd0, 1'b0, 1'b0);
      step(1);
      chk4("p1_yellow", 3'b010, 8'd1, 1'b1, 1'b0);
      step(2);
      chk4("p1_ack", 3'b000, 8'd3, 1'b1, 1'b1);
      step(1);
      chk4("p1_ack_end", 3'b000, 8'd2, 1'b0, 1'b0);

      // A request at green remaining=1 does not cut GREEN.
      step(7);
      chk4("p2_green1", 3'b001, 8'd1, 1'b0, 1'b0);
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      chk4("p2_nocut", 3'b001, 8'd0, 1'b0, 1'b0);
      step(1);
      chk4("p2_yellow", 3'b010, 8'd1, 1'b1, 1'b0);
      step(2);
      chk4("p2_ack", 3'b000, 8'd3, 1'b1, 1'b1);

      // A request made during RED stays pending, then reset clears it.
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      chk4("p3_red", 3'b000, 8'd2, 1'b0, 1'b0);
      step(3);
      chk4("p3_green", 3'b001, 8'd5, 1'b1, 1'b0);
      step(1);
      chk4("p3_cut", 3'b001, 8'd1, 1'b0, 1'b0);
      step(3);
      chk4("p3_yellow0", 3'b010, 8'd0, 1'b0, 1'b0);
      reset_mid_yellow();
`else
      // With ped_req held high, GREEN still runs its full 6 cycles and there
      // is no acknowledge.
      ped_req = 1'b1;
      step(4);
      for (int i = 0; i < 6; i++) begin
         chk4("noped_green", 3'b001, 8'(5 - i), (i == 0), 1'b0);
         step(1);
      end
      chk4("noped_yellow", 3'b010, 8'd1, 1'b1, 1'b0);
      step(2);
      chk4("noped_red", 3'b000, 8'd3, 1'b1, 1'b0);
      step(11);
      chk4("noped_yellow0", 3'b010, 8'd0, 1'b0, 1'b0);
      reset_mid_yellow();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
